// File: rtl/fp_accumulate_pkg.sv
// Shared FP32 constants, field layout and accumulator FSM encoding for the
// streaming accumulator.
package fp_pkg;

  localparam int          FP_EXP_W = 8;
  localparam int          FP_MAN_W = 23;
  localparam int          FP_BIAS  = 127;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NINF  = 32'hFF80_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    ACC_IDLE  = 3'd0,
    ACC_ALIGN = 3'd1,
    ACC_ADD   = 3'd2,
    ACC_NORM  = 3'd3,
    ACC_OUT   = 3'd4
  } acc_state_t;

endpackage

// File: rtl/fp_accumulate_if.sv
// Addend input stream and packet-sum output stream of the accumulator.
interface fp_accumulate_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fp_accumulate_norm_round.sv
// Normalises a 28-bit sum (carry, hidden, 23 fraction, guard/round/sticky),
// rounds to nearest-even and clamps to +0 / +-inf on under/overflow.
module fp32_norm_round
  import fp_pkg::*;
(
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [27:0] sig_i,
  output logic [31:0] result_o
);

  logic [4:0]  lz;
  logic [26:0] m;
  logic [9:0]  e;
  logic        round_up;
  logic [24:0] mant;
  logic [23:0] mant_n;
  fp32_t       res;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sig_i[i]) lz = 5'(26 - i);
    end

    if (sig_i[27]) begin
      m = {sig_i[27:2], sig_i[1] | sig_i[0]};
      e = {2'b00, exp_i} + 10'd1;
    end else begin
      m = sig_i[26:0] << lz;
      e = {2'b00, exp_i} - {5'b00000, lz};
    end

    round_up = m[2] & (m[1] | m[0] | m[3]);
    mant     = {1'b0, m[26:3]} + {24'd0, round_up};
    // A rounding carry leaves 1.000..0, so only the exponent moves.
    if (mant[24]) begin
      mant_n = mant[24:1];
      e      = e + 10'd1;
    end else begin
      mant_n = mant[23:0];
    end

    res.sign = sign_i;
    res.exp  = e[7:0];
    res.man  = mant_n[22:0];

    if (sig_i == 28'd0 || e[9] || e == 10'd0) begin
      result_o = 32'h0000_0000;
    end else if (e >= 10'd255) begin
      result_o = sign_i ? FP_NINF : FP_PINF;
    end else begin
      result_o = res;
    end
  end

endmodule

// File: rtl/fp_accumulate.sv
// Packet-wise FP32 accumulator: one shared align/add/normalise datapath
// stepped by a small FSM, one sum emitted per in_last-terminated packet.
//
// state | meaning
// IDLE  | ready for an addend; latch it and its last flag
// ALIGN | unpack, flush, resolve specials, swap, align smaller operand
// ADD   | add or subtract aligned significands
// NORM  | normalise, round, write acc; go to OUT on last
// OUT   | present acc until out_ready, then clear acc
module fp_accumulate
  import fp_pkg::*;
(
  input  logic            aclk,
  input  logic            aresetn,
  fp_accumulate_if.slave  s_if,
  output logic            busy
);

  localparam logic [2:0] S_IDLE  = ACC_IDLE;
  localparam logic [2:0] S_ALIGN = ACC_ALIGN;
  localparam logic [2:0] S_ADD   = ACC_ADD;
  localparam logic [2:0] S_NORM  = ACC_NORM;
  localparam logic [2:0] S_OUT   = ACC_OUT;

  logic [2:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] add_q, add_d;
  logic        last_q, last_d;
  logic [26:0] sig_a_q, sig_a_d;
  logic [26:0] sig_b_q, sig_b_d;
  logic [7:0]  exp_a_q, exp_a_d;
  logic        sign_a_q, sign_a_d;
  logic        eff_sub_q, eff_sub_d;
  logic        special_q, special_d;
  logic [31:0] special_val_q, special_val_d;
  logic [27:0] sum_q, sum_d;

  fp32_t       ua, ub, fa, fb;
  logic        swap;
  logic [7:0]  exp_diff;
  logic [26:0] sig_a_full, sig_b_full, sig_b_shift, shift_mask, sig_b_align;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [31:0] norm_res;

  always_comb begin
    ua = fp32_t'(acc_q);
    ub = fp32_t'(add_q);
    // Subnormals flush to +0; signed zeros are kept for the -0 + -0 case.
    if (ua.exp == 8'h00 && ua.man != 23'd0) ua = '0;
    if (ub.exp == 8'h00 && ub.man != 23'd0) ub = '0;

    swap = {ub.exp, ub.man} > {ua.exp, ua.man};
    fa   = swap ? ub : ua;
    fb   = swap ? ua : ub;

    exp_diff   = fa.exp - fb.exp;
    sig_a_full = {fa.exp != 8'h00, fa.man, 3'b000};
    sig_b_full = {fb.exp != 8'h00, fb.man, 3'b000};
    if (exp_diff >= 8'd27) begin
      sig_b_shift = 27'd0;
      shift_mask  = '1;
    end else begin
      sig_b_shift = sig_b_full >> exp_diff;
      shift_mask  = (27'd1 << exp_diff) - 27'd1;
    end
    sig_b_align = {sig_b_shift[26:1], sig_b_shift[0] | (|(sig_b_full & shift_mask))};

    nan_a  = (ua.exp == 8'hFF) && (ua.man != 23'd0);
    nan_b  = (ub.exp == 8'hFF) && (ub.man != 23'd0);
    inf_a  = (ua.exp == 8'hFF) && (ua.man == 23'd0);
    inf_b  = (ub.exp == 8'hFF) && (ub.man == 23'd0);
    zero_a = (ua.exp == 8'h00) && (ua.man == 23'd0);
    zero_b = (ub.exp == 8'h00) && (ub.man == 23'd0);

    spec_hit = 1'b1;
    spec_val = FP_QNAN;
    if (nan_a || nan_b) begin
      spec_val = FP_QNAN;
    end else if (inf_a && inf_b && (ua.sign != ub.sign)) begin
      spec_val = FP_QNAN;
    end else if (inf_a) begin
      spec_val = ua;
    end else if (inf_b) begin
      spec_val = ub;
    end else if (zero_a && zero_b && ua.sign && ub.sign) begin
      spec_val = 32'h8000_0000;
    end else begin
      spec_hit = 1'b0;
    end
  end

  fp32_norm_round u_norm_round (
    .sign_i   (sign_a_q),
    .exp_i    (exp_a_q),
    .sig_i    (sum_q),
    .result_o (norm_res)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    add_d         = add_q;
    last_d        = last_q;
    sig_a_d       = sig_a_q;
    sig_b_d       = sig_b_q;
    exp_a_d       = exp_a_q;
    sign_a_d      = sign_a_q;
    eff_sub_d     = eff_sub_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    sum_d         = sum_q;

    case (state_q)
      S_IDLE: begin
        if (s_if.in_valid) begin
          add_d   = s_if.in_data;
          last_d  = s_if.in_last;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sig_a_d       = sig_a_full;
        sig_b_d       = sig_b_align;
        exp_a_d       = fa.exp;
        sign_a_d      = fa.sign;
        eff_sub_d     = fa.sign ^ fb.sign;
        special_d     = spec_hit;
        special_val_d = spec_val;
        state_d       = S_ADD;
      end
      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                            : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        acc_d   = special_q ? special_val_q : norm_res;
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (s_if.out_ready) begin
          acc_d   = 32'h0000_0000;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      acc_q         <= 32'h0000_0000;
      add_q         <= 32'h0000_0000;
      last_q        <= 1'b0;
      sig_a_q       <= 27'd0;
      sig_b_q       <= 27'd0;
      exp_a_q       <= 8'd0;
      sign_a_q      <= 1'b0;
      eff_sub_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'h0000_0000;
      sum_q         <= 28'd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      add_q         <= add_d;
      last_q        <= last_d;
      sig_a_q       <= sig_a_d;
      sig_b_q       <= sig_b_d;
      exp_a_q       <= exp_a_d;
      sign_a_q      <= sign_a_d;
      eff_sub_q     <= eff_sub_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      sum_q         <= sum_d;
    end
  end

  assign s_if.in_ready  = (state_q == S_IDLE);
  assign s_if.out_valid = (state_q == S_OUT);
  assign s_if.out_data  = acc_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_accumulate.sv
// Directed-vector bench for fp_accumulate with hand-computed packet sums.
module tb_fp_accumulate;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  fp_accumulate_if ifc ();

  fp_accumulate dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_if    (ifc),
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an addend from a negedge and hold it until accepted at a posedge.
  task automatic drive(input logic [31:0] d, input logic l);
    int waitc = 0;
    @(negedge aclk);
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    ifc.in_last  = l;
    while (!ifc.in_ready && waitc < 20) begin
      @(negedge aclk);
      waitc++;
    end
    if (!ifc.in_ready) begin
      check("accept_timeout", {31'd0, ifc.in_ready}, 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.in_data  = 32'hDEAD_BEEF;
    check("in_ready_low_after_accept", {31'd0, ifc.in_ready}, 32'd0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Called right after the last addend's accept edge; out_valid is due 4 cycles later.
  task automatic wait_valid(input string tag);
    int lat = 0;
    while (!ifc.out_valid && lat < 12) begin
      @(negedge aclk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic take_out(input string tag, input logic [31:0] exp);
    check(tag, ifc.out_data, exp);
    check({tag, "_in_ready_in_out"}, {31'd0, ifc.in_ready}, 32'd0);
    ifc.out_ready = 1'b1;
    @(posedge aclk);
    #1;
    ifc.out_ready = 1'b0;
    check({tag, "_out_valid_after_hs"}, {31'd0, ifc.out_valid}, 32'd0);
    check({tag, "_in_ready_after_hs"}, {31'd0, ifc.in_ready}, 32'd1);
  endtask

  task automatic packet2(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    drive(a, 1'b0);
    drive(b, 1'b1);
    wait_valid(tag);
    take_out(tag, exp);
  endtask

  initial begin
    ifc.in_data   = 32'h0;
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", ifc.out_data, 32'h0000_0000);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    packet2("mixed_sign", 32'h4010_0000, 32'hC10C_0000, 32'hC0D0_0000);
    packet2("tie_even_down", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    packet2("tie_odd_up", 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    packet2("cancel", 32'h4010_0000, 32'hC010_0000, 32'h0000_0000);
    drive(32'h3FC0_0000, 1'b1);
    wait_valid("acc_cleared");
    take_out("acc_cleared", 32'h3FC0_0000);
    packet2("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    packet2("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    packet2("nan_in", 32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000);
    packet2("ninf_plus_one", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    drive(32'h0000_0001, 1'b1);
    wait_valid("subnormal_flush");
    take_out("subnormal_flush", 32'h0000_0000);

    // Backpressure: hold out_ready low for 5 cycles
    drive(32'h3F80_0000, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_out_data_stable", ifc.out_data, 32'h3F80_0000);
      check("bp_out_valid_held", {31'd0, ifc.out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    end
    take_out("bp", 32'h3F80_0000);

    // Reset while in ADD
    drive(32'h4000_0000, 1'b1);
    @(negedge aclk);
    @(negedge aclk);
    check("midop_busy_before_rst", {31'd0, busy}, 32'd1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("midop_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("midop_busy", {31'd0, busy}, 32'd0);
    check("midop_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    check("midop_out_data", ifc.out_data, 32'h0000_0000);
    @(negedge aclk);
    aresetn = 1'b1;
    drive(32'h3F80_0000, 1'b1);
    wait_valid("after_rst");
    take_out("after_rst", 32'h3F80_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accumulate.md
# fp_accumulate

Streaming single-precision accumulator downstream of `fpMult`. It consumes the FP32 product stream, sums each packet (delimited by `in_last`) into a running FP32 total and emits one result per packet. Addition runs in a multi-cycle FSM (align, add, normalise/round) that reuses one datapath. This makes the multiplier and accumulator pair a complete dot-product path.

## Interface
- No parameters; format fixed to IEEE-754 binary32.
- `aclk` in 1: sole clock, all logic on rising edge.
- `aresetn` in 1: synchronous, active-low reset.
- `in_data` in 32: FP32 addend (product from `fpMult`).
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_ready` out 1: block can accept an addend.
- `in_last` in 1: addend is the final one of the packet.
- `out_data` out 32: FP32 packet sum.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `busy` out 1: FSM not in IDLE.

## Operation
- **States:** IDLE, ALIGN, ADD, NORM, OUT.
- **Accumulator reset:** accumulator `acc` resets to +0.0 (0x00000000).
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_data` and `in_last`, then go to ALIGN.
- **ALIGN:**
  - Unpack `acc` and the addend, with hidden bit and 3 extra bits (guard, round, sticky), giving a 27-bit significand.
  - Swap so operand A has the larger magnitude.
  - Right-shift B by the exponent difference. Bits shifted out OR into sticky.
  - A shift ≥ 27 leaves only sticky.
- **ADD:**
  - Add the significands if the signs match, otherwise subtract (A−B).
  - The result is 28 bits and carries A's sign.
- **NORM:**
  - On carry-out, right-shift by 1 (sticky preserved) and increment the exponent.
  - Otherwise left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even. A rounding carry renormalises.
  - Write `acc`.
  - Go to OUT if the latched last flag is set, else IDLE.
- **OUT:**
  - `out_valid`=1 and `out_data`=`acc`.
  - On `out_ready`, `acc` is set to +0.0 and the FSM returns to IDLE.
- **Special cases** (resolved in ALIGN, result forced in NORM):
  - Subnormal input or `acc` is flushed to +0.
  - Exponent underflow after normalisation gives +0.
  - Overflow gives ±inf (0x7F800000/0xFF800000).
  - Any NaN input gives canonical NaN 0x7FC00000.
  - +inf plus −inf gives 0x7FC00000.
  - inf plus a finite value gives that inf.
  - Exact cancellation gives +0.0.
  - −0 plus −0 gives −0.
- **Single-addend packet:** result is 0 + x, i.e. x, after flushing and NaN canonicalisation.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0x00000000, `busy`=0, state IDLE, `acc`=+0.0.
  - `in_ready`=1 from the first cycle after reset release.
- **Accept at edge N:** ALIGN at N+1, ADD at N+2, NORM at N+3.
  - `in_ready` is high again at cycle N+4 for a non-last addend.
  - Throughput is one addend per 4 cycles.
- **Last addend accepted at N:** `out_valid` rises at N+4.
- **Backpressure:**
  - `out_valid` and `out_data` hold stable until `out_ready`.
  - `in_ready`=0 throughout OUT.
  - `out_valid` falls the cycle after the handshake.
  - `in_ready` is 1 that same cycle.
- **`in_ready` is a registered state decode:** it does not depend combinationally on `in_valid`.
- **Reset mid-operation** (any state): the in-flight addend and partial sum are discarded, with no output.
  - All reset values apply on the next edge.
- **Input holding:** `in_valid` may drop or hold while `in_ready`=0. Data is not sampled outside IDLE.

## Structure
- **Package `fp_pkg`:**
  - Constants: `FP_EXP_W`=8, `FP_MAN_W`=23, `FP_BIAS`=127, `FP_QNAN`=32'h7FC00000, `FP_PINF`, `FP_NINF`.
  - Packed struct `fp32_t` with fields `sign`, `exp`, `man`.
  - Enum `acc_state_t` with the five states.
- **Sub-module `fp32_norm_round`:**
  - Combinational.
  - Takes sign, exponent and 28-bit significand.
  - Returns the packed FP32 result: leading-zero count, shift, RNE and overflow/underflow clamp.
  - Used in NORM.
- Everything else lives inline in `fp_accumulate`.

## Test plan
- **Mixed-sign packet:** packet 0x40100000 (2.25), then 0xC10C0000 (−8.75, `in_last`).
  - `out_data`=0xC0D00000 (−6.5), `out_valid` 4 cycles after the last accept.
- **Round ties-to-even:** packet 0x3F800000, then 0x33800000 (`in_last`, 2^-24).
  - Result 0x3F800000.
- **Cancellation then accumulator clear:** packet 0x40100000, then 0xC0100000 (last).
  - Result 0x00000000.
  - The next packet 0x3FC00000 (last) gives 0x3FC00000, proving `acc` was cleared.
- **Overflow:** 0x7F7FFFFF plus 0x7F7FFFFF gives 0x7F800000.
- **inf/NaN:** 0x7F800000 plus 0xFF800000 gives 0x7FC00000.
- **Subnormal flush:** single subnormal 0x00000001 (last) gives 0x00000000.
- **Backpressure and reset mid-op:**
  - Hold `out_ready`=0 for 5 cycles: `out_data` stays stable and `in_ready`=0.
  - Assert `aresetn`=0 during ADD: next cycle `out_valid`=0, `busy`=0, `in_ready`=1.
  - A following 0x3F800000 (last) then gives 0x3F800000.
